// File: rtl/r0_multiplexer.sv
// Registered two-output router for the R0 register path: pass, load R0, swap or read R0,
// with results presented one clock after acceptance and qualified by ready.
module r0_multiplexer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       state,
  input  logic [WIDTH-1:0] value1,
  input  logic [WIDTH-1:0] value2,
  output logic [WIDTH-1:0] Output1,
  output logic [WIDTH-1:0] Output2,
  output logic             ready
);

  localparam logic [1:0] OP_PASS    = 2'd0;
  localparam logic [1:0] OP_LOAD_R0 = 2'd1;
  localparam logic [1:0] OP_SWAP    = 2'd2;
  localparam logic [1:0] OP_READ_R0 = 2'd3;

  logic [WIDTH-1:0] r0_reg,   r0_next;
  logic [WIDTH-1:0] out1_reg, out1_next;
  logic [WIDTH-1:0] out2_reg, out2_next;
  logic             ready_reg, ready_next;

  // One-hot decode of the operation; only meaningful while en is high.
  logic sel_load, sel_swap, sel_read;

  always_comb begin
    sel_load = (state == OP_LOAD_R0);
    sel_swap = (state == OP_SWAP);
    sel_read = (state == OP_READ_R0);
  end

  // Per-bit selection keeps each output bit a small 4:1 mux ahead of its flop.
  // PASS falls through to the default operand ordering.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      always_comb begin
        r0_next[gi]   = r0_reg[gi];
        out1_next[gi] = out1_reg[gi];
        out2_next[gi] = out2_reg[gi];
        if (en) begin
          out1_next[gi] = value1[gi];
          out2_next[gi] = value2[gi];
          if (sel_load) begin
            r0_next[gi] = value1[gi];
          end
          if (sel_swap) begin
            out1_next[gi] = value2[gi];
            out2_next[gi] = value1[gi];
          end
          if (sel_read) begin
            out1_next[gi] = r0_reg[gi];
          end
        end
      end
    end
  endgenerate

  always_comb begin
    ready_next = en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r0_reg    <= '0;
      out1_reg  <= '0;
      out2_reg  <= '0;
      ready_reg <= 1'b0;
    end else begin
      r0_reg    <= r0_next;
      out1_reg  <= out1_next;
      out2_reg  <= out2_next;
      ready_reg <= ready_next;
    end
  end

  assign Output1 = out1_reg;
  assign Output2 = out2_reg;
  assign ready   = ready_reg;

  // OP_PASS is the implicit default path above; referenced here so the full code map stays visible.
  logic unused_pass;
  assign unused_pass = (state == OP_PASS);

endmodule

// File: tb/tb_r0_multiplexer.sv
// Directed-vector bench for r0_multiplexer: hand-computed expectations checked one clock after each edge.
module tb_r0_multiplexer;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] state;
  logic [7:0] value1;
  logic [7:0] value2;
  logic [7:0] Output1;
  logic [7:0] Output2;
  logic       ready;

  int checks = 0;
  int errors = 0;

  r0_multiplexer #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .state  (state),
    .value1 (value1),
    .value2 (value2),
    .Output1(Output1),
    .Output2(Output2),
    .ready  (ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drive on the falling edge, then sample 1 time unit after the next rising edge.
  task automatic step(input logic e, input logic [1:0] s, input logic [7:0] v1, input logic [7:0] v2);
    @(negedge clk);
    en = e; state = s; value1 = v1; value2 = v2;
    @(posedge clk);
    #1;
    $display("txn rst=%0b en=%0b state=%0d v1=%h v2=%h -> o1=%h o2=%h ready=%0b",
             rst, e, s, v1, v2, Output1, Output2, ready);
  endtask

  task automatic expect_out(input string tag, input logic [7:0] o1, input logic [7:0] o2, input logic rdy);
    check({tag, ".o1"}, Output1, o1);
    check({tag, ".o2"}, Output2, o2);
    check({tag, ".rdy"}, {7'd0, ready}, {7'd0, rdy});
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; state = 2'd0; value1 = 8'h00; value2 = 8'h00;

    // Reset held two cycles while a load is requested.
    step(1'b1, 2'd1, 8'hAA, 8'h55);
    step(1'b1, 2'd1, 8'hAA, 8'h55);
    expect_out("reset", 8'h00, 8'h00, 1'b0);
    rst = 1'b0;
    step(1'b1, 2'd3, 8'h11, 8'h00);
    expect_out("read_after_reset", 8'h00, 8'h00, 1'b1);

    // Load then read.
    step(1'b1, 2'd1, 8'h01, 8'h02);
    expect_out("load", 8'h01, 8'h02, 1'b1);
    step(1'b1, 2'd3, 8'h09, 8'h02);
    expect_out("read", 8'h01, 8'h02, 1'b1);

    // Pass and swap.
    step(1'b1, 2'd0, 8'h12, 8'h34);
    expect_out("pass", 8'h12, 8'h34, 1'b1);
    step(1'b1, 2'd2, 8'h12, 8'h34);
    expect_out("swap", 8'h34, 8'h12, 1'b1);

    // Hold with en low; R0 retained.
    step(1'b0, 2'd1, 8'h77, 8'h88);
    expect_out("hold1", 8'h34, 8'h12, 1'b0);
    step(1'b0, 2'd3, 8'h55, 8'h66);
    expect_out("hold2", 8'h34, 8'h12, 1'b0);
    step(1'b1, 2'd3, 8'h00, 8'hC3);
    expect_out("read_after_hold", 8'h01, 8'hC3, 1'b1);

    // Back-to-back load/read alternation.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'd1, 8'hFF, 8'(i));
      expect_out("b2b_load", 8'hFF, 8'(i), 1'b1);
      step(1'b1, 2'd3, 8'h00, 8'(i + 8'h40));
      expect_out("b2b_read", 8'hFF, 8'(i + 8'h40), 1'b1);
    end

    // Load zero boundary.
    step(1'b1, 2'd1, 8'h00, 8'h07);
    expect_out("load_zero", 8'h00, 8'h07, 1'b1);
    step(1'b1, 2'd3, 8'h05, 8'h08);
    expect_out("read_zero", 8'h00, 8'h08, 1'b1);

    // Mid-stream reset discards R0 and outputs.
    step(1'b1, 2'd1, 8'h5A, 8'hA5);
    expect_out("load_5a", 8'h5A, 8'hA5, 1'b1);
    rst = 1'b1;
    step(1'b1, 2'd3, 8'h33, 8'h44);
    expect_out("mid_reset", 8'h00, 8'h00, 1'b0);
    rst = 1'b0;
    step(1'b1, 2'd3, 8'h33, 8'h44);
    expect_out("read_after_mid_reset", 8'h00, 8'h44, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=%0d expected=%0d", checks, 0);
    $fatal(1, "timeout");
  end

endmodule
